// File: rtl/partial_load_unit.sv
// RV32 load-data aligner: byte/halfword/word select with sign/zero extension,
// misaligned-load flag and a saturating misalignment counter. Optional macro
// PARTIAL_LOAD_OUT_REG_EN registers data_to_reg and misaligned by one cycle.
module partial_load_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic [31:0]      data_from_mem,
  input  logic [31:0]      mem_addr,
  input  logic             load_valid,
  output logic [31:0]      data_to_reg,
  output logic             misaligned,
  output logic [CNT_W-1:0] misalign_count
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [2:0] F3_LB    = 3'b000;
  localparam logic [2:0] F3_LH    = 3'b001;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;

  logic [2:0]       w_funct3;
  logic             w_is_load;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_data;
  logic             w_misaligned;
  logic [CNT_W-1:0] r_count;
  logic             w_unused;

  assign w_funct3  = instruction[14:12];
  assign w_is_load = (instruction[6:0] == OPC_LOAD);
  // Only the low address bits and the opcode/funct3 fields matter here.
  assign w_unused  = ^{mem_addr[31:2], instruction[31:15], instruction[11:7]};

  always_comb begin
    w_byte = data_from_mem[7:0];
    case (mem_addr[1:0])
      2'd0: w_byte = data_from_mem[7:0];
      2'd1: w_byte = data_from_mem[15:8];
      2'd2: w_byte = data_from_mem[23:16];
      2'd3: w_byte = data_from_mem[31:24];
      default: w_byte = data_from_mem[7:0];
    endcase
  end

  assign w_half = mem_addr[1] ? data_from_mem[31:16] : data_from_mem[15:0];

  always_comb begin
    w_data = data_from_mem;
    if (w_is_load) begin
      case (w_funct3)
        F3_LB:   w_data = {{24{w_byte[7]}}, w_byte};
        F3_LBU:  w_data = {24'b0, w_byte};
        F3_LH:   w_data = {{16{w_half[15]}}, w_half};
        F3_LHU:  w_data = {16'b0, w_half};
        default: w_data = data_from_mem;
      endcase
    end
  end

  always_comb begin
    w_misaligned = 1'b0;
    if (w_is_load) begin
      case (w_funct3)
        F3_LH, F3_LHU: w_misaligned = mem_addr[0];
        F3_LW:         w_misaligned = |mem_addr[1:0];
        default:       w_misaligned = 1'b0;
      endcase
    end
  end

  // Saturating debug counter; always driven by the unregistered flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (load_valid && w_misaligned && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign misalign_count = r_count;

`ifdef PARTIAL_LOAD_OUT_REG_EN
  logic [31:0] r_data;
  logic        r_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_data       <= w_data;
      r_misaligned <= w_misaligned;
    end
  end

  assign data_to_reg = r_data;
  assign misaligned  = r_misaligned;
`else
  assign data_to_reg = w_data;
  assign misaligned  = w_misaligned;
`endif

endmodule

// File: tb/tb_partial_load_unit.sv
// Self-checking bench for partial_load_unit (default, combinational build):
// directed literal cases, counter/reset/saturation cases and randomized traffic.
module tb_partial_load_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] data_from_mem;
  logic [31:0] mem_addr;
  logic        load_valid;
  logic [31:0] data_to_reg;
  logic        misaligned;
  logic [15:0] misalign_count;
  logic [31:0] dataSmall;
  logic        misSmall;
  logic [3:0]  countSmall;

  int cmpCount  = 0;
  int failCount = 0;
  int modelCnt  = 0;
  int modelCntSmall = 0;
  bit checkEn   = 0;

  partial_load_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .data_from_mem(data_from_mem),
    .mem_addr(mem_addr), .load_valid(load_valid), .data_to_reg(data_to_reg),
    .misaligned(misaligned), .misalign_count(misalign_count)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  partial_load_unit #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .instruction(instruction), .data_from_mem(data_from_mem),
    .mem_addr(mem_addr), .load_valid(load_valid), .data_to_reg(dataSmall),
    .misaligned(misSmall), .misalign_count(countSmall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkInstr(input int f3, input bit isLoad);
    logic [31:0] ins;
    ins = $urandom;
    ins[14:12] = f3[2:0];
    ins[6:0] = isLoad ? 7'b0000011 : 7'b0110011;
    return ins;
  endfunction

  function automatic logic [31:0] modelData(input logic [31:0] ins, input logic [31:0] d,
                                            input logic [31:0] a);
    int unsigned b, h, f3;
    b  = (d >> (8 * (a % 4))) & 32'hFF;
    h  = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    f3 = ins[14:12];
    if (ins[6:0] != 7'b0000011) return d;
    case (f3)
      0: return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      4: return b;
      1: return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      5: return h;
      default: return d;
    endcase
  endfunction

  function automatic bit modelMis(input logic [31:0] ins, input logic [31:0] a);
    int unsigned f3;
    f3 = ins[14:12];
    if (ins[6:0] != 7'b0000011) return 1'b0;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] d,
                               input logic [31:0] a, input logic v);
    @(posedge clk);
    #2;
    instruction   = ins;
    data_from_mem = d;
    mem_addr      = a;
    load_valid    = v;
  endtask

  task automatic directed(input string name, input logic [31:0] ins, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] expData, input logic expMis);
    applyStimulus(ins, d, a, 1'b0);
    #45;
    checkOutput({name, ".model"}, modelData(ins, d, a), expData);
    checkOutput({name, ".data"}, data_to_reg, expData);
    checkOutput({name, ".mis"}, {31'b0, misaligned}, {31'b0, expMis});
  endtask

  // Reference counter: saturating count of qualified misaligned loads.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelCnt      = 0;
      modelCntSmall = 0;
    end else if (load_valid && modelMis(instruction, mem_addr)) begin
      if (modelCnt < 65535) modelCnt = modelCnt + 1;
      if (modelCntSmall < 15) modelCntSmall = modelCntSmall + 1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc.data", data_to_reg, modelData(instruction, data_from_mem, mem_addr));
      checkOutput("cyc.mis", {31'b0, misaligned}, {31'b0, modelMis(instruction, mem_addr)});
      checkOutput("cyc.cnt", {16'b0, misalign_count}, modelCnt);
      checkOutput("cyc.dataS", dataSmall, modelData(instruction, data_from_mem, mem_addr));
      checkOutput("cyc.misS", {31'b0, misSmall}, {31'b0, modelMis(instruction, mem_addr)});
      checkOutput("cyc.cntS", {28'b0, countSmall}, modelCntSmall);
    end
  end

  initial begin
    rst = 1'b1;
    instruction = '0;
    data_from_mem = '0;
    mem_addr = '0;
    load_valid = 1'b0;
    #3;
    checkOutput("reset.cnt", {16'b0, misalign_count}, 32'd0);
    checkOutput("reset.cntS", {28'b0, countSmall}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    checkEn = 1'b1;

    directed("lb_a1",   mkInstr(0, 1), 32'h12345678, 32'd1, 32'h00000056, 1'b0);
    directed("lh_a0",   mkInstr(1, 1), 32'h89ABCDEF, 32'd0, 32'hFFFFCDEF, 1'b0);
    directed("lhu_a2",  mkInstr(5, 1), 32'h89ABCDEF, 32'd2, 32'h000089AB, 1'b0);
    directed("lw_a3",   mkInstr(2, 1), 32'h12345678, 32'd3, 32'h12345678, 1'b1);
    directed("nonload", 32'h00000000,  32'h87654321, 32'd0, 32'h87654321, 1'b0);
    directed("lbu_a2",  mkInstr(4, 1), 32'h89ABCDEF, 32'd2, 32'h000000AB, 1'b0);
    directed("lb_a2",   mkInstr(0, 1), 32'h89ABCDEF, 32'd2, 32'hFFFFFFAB, 1'b0);
    directed("lh_a1",   mkInstr(1, 1), 32'h89ABCDEF, 32'd1, 32'hFFFFCDEF, 1'b1);
    directed("f3_011",  mkInstr(3, 1), 32'h89ABCDEF, 32'd1, 32'h89ABCDEF, 1'b0);
    directed("lhu_a3",  mkInstr(5, 1), 32'h89ABCDEF, 32'h0000FFF3, 32'h000089AB, 1'b1);

    // Reset pulse, then three valid misaligned halfword loads.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    applyStimulus(mkInstr(1, 1), 32'h89ABCDEF, 32'd1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    load_valid = 1'b0;
    #1;
    checkOutput("cnt.three", {16'b0, misalign_count}, 32'd3);

    // Asynchronous clear between edges.
    rst = 1'b1;
    #1;
    checkOutput("cnt.asyncClr", {16'b0, misalign_count}, 32'd0);
    checkOutput("cnt.asyncClrS", {28'b0, countSmall}, 32'd0);
    #2;
    rst = 1'b0;

    // Drive the narrow counter past all-ones.
    applyStimulus(mkInstr(2, 1), 32'hDEADBEEF, 32'd3, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    load_valid = 1'b0;
    #1;
    checkOutput("cnt.twenty", {16'b0, misalign_count}, 32'd20);
    checkOutput("cnt.satS", {28'b0, countSmall}, 32'd15);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      rst           = ($urandom_range(0, 99) == 0);
      instruction   = $urandom;
      if ($urandom_range(0, 4) != 0) instruction[6:0] = 7'b0000011;
      data_from_mem = $urandom;
      mem_addr      = $urandom;
      load_valid    = $urandom_range(0, 1) == 1;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    #1;
    checkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
